// File: rtl/srt_otf_quotient_converter.sv
// Radix-4 SRT on-the-fly quotient converter: tracks Q and Q-1 one signed digit at a time, no CPA.
// Quotient is registered 1 clk after the last digit; held with q_valid until q_ready. Optional OTFC_DIGIT_CHECK_EN adds a sticky digit_err.
module srt_otf_quotient_converter #(
    parameter int NDIGITS = 13,
    parameter int W       = 2 * NDIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         digit_valid,
    input  logic [2:0]   digit,
    input  logic         final_rem_neg,
    output logic         digit_ready,
    output logic         q_valid,
    input  logic         q_ready,
    output logic [W-1:0] quotient,
    output logic         busy
`ifdef OTFC_DIGIT_CHECK_EN
    ,
    output logic         digit_err
`endif
);

    localparam int CW = $clog2(NDIGITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d, qm_q, qm_d, quo_q, quo_d;
    logic [W-1:0]   q_nx, qm_nx;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     dig;
    logic [1:0]     lo_dec, lo_inc;
    logic           d_neg, d_pos, xfer, last;

    // -4 is outside the redundant digit set; it is absorbed as 0.
    always_comb begin
        dig    = (digit == 3'b100) ? 3'b000 : digit;
        d_neg  = dig[2];
        d_pos  = !dig[2] && (dig[1:0] != 2'b00);
        lo_dec = dig[1:0] - 2'd1;
        lo_inc = dig[1:0] + 2'd3;
        q_nx   = d_neg ? {qm_q[W-3:0], dig[1:0]} : {q_q[W-3:0], dig[1:0]};
        qm_nx  = d_pos ? {q_q[W-3:0], lo_dec}    : {qm_q[W-3:0], lo_inc};
    end

    assign xfer        = (state_q == RUN) && digit_valid;
    assign last        = (cnt_q == CW'(NDIGITS - 1));
    assign digit_ready = (state_q == RUN);
    assign q_valid     = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign quotient    = quo_q;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        case (state_q)
            RUN: begin
                if (xfer) begin
                    q_d   = q_nx;
                    qm_d  = qm_nx;
                    cnt_d = cnt_q + CW'(1);
                    if (last) begin
                        state_d = DONE;
                        quo_d   = final_rem_neg ? qm_nx : q_nx;
                    end
                end
            end
            DONE: begin
                if (q_ready) state_d = IDLE;
            end
            default: ;
        endcase
        // Start overrides any concurrent digit transfer or result handoff.
        if (start) begin
            state_d = RUN;
            q_d     = '0;
            qm_d    = '1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
        end
    end

`ifdef OTFC_DIGIT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (start)
            err_d = 1'b0;
        else if (xfer && (digit == 3'b100))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign digit_err = err_q;
`endif

endmodule
